serial_xfer_ctrl: RTL
=====================

# serial_xfer_ctrl

Controller that sequences one full-duplex serial transfer on `sclk`, `sdo` and `sdi`. A transfer is requested by `en` together with `start`. The block generates `sclk`, shifts out a WIDTH-bit word MSB first and captures WIDTH bits from `sdi`. `start` must stay high for the whole transfer; if it drops, the block aborts, so the `start throughout sclk-activity` property holds by construction.

## Interface
- `WIDTH`, default 4: bits per transfer (≥1).
- `DIV`, default 1: `sclk` half-period in `clk` cycles (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: transfer request qualifier, sampled only in IDLE.
- `start` in 1: transfer request/hold level; must remain 1 throughout SHIFT.
- `din` in WIDTH: transmit word, latched at transfer accept.
- `sdi` in 1: serial input.
- `sclk` out 1: serial clock, idles 0.
- `sdo` out 1: serial output, MSB first.
- `busy` out 1: high while in SHIFT.
- `done` out 1: one-cycle pulse on normal completion.
- `abort` out 1: one-cycle pulse when `start` drops mid-transfer.
- `dout` out WIDTH: last completed receive word.

## Operation
- States: IDLE and SHIFT.
- Reset values: state IDLE; `sclk`, `sdo`, `busy`, `done` and `abort` all 0; `dout` = 0; divider, bit counter and shift registers 0.
- IDLE → SHIFT when `en && start` is sampled high.
  - `din` is copied to the TX shift register.
  - `sdo` = `din[WIDTH-1]`; `sclk` = 0; divider = 0; toggle count = 0.
- In SHIFT the divider counts 0..DIV-1. At DIV-1, `sclk` toggles, the divider clears and the toggle count increments.
- Rising toggle (`sclk` 0→1): `sdi` is shifted into the RX register LSB (shift left), so the first bit captured is the MSB.
- Falling toggle (`sclk` 1→0) other than the last: the TX register shifts left and `sdo` presents the next bit.
- Last falling toggle (toggle 2·WIDTH):
  - Next state IDLE; `dout` ← RX register; `done` = 1 for one cycle.
  - `busy` = 0, `sclk` = 0, `sdo` = 0.
- Abort: any SHIFT cycle that samples `start` = 0 goes to IDLE on the next edge.
  - `sclk` = 0, `sdo` = 0, `busy` = 0, `abort` = 1 for one cycle.
  - `dout` is unchanged and no `done` pulse is issued.
- Abort has priority over completion when both fall on the same cycle.
- `en` and `din` are ignored during SHIFT.
- Reset mid-transfer: all outputs return to reset values on the next edge and no pulses are produced.

## Timing
- Accept sampled at edge N: `busy` = 1 from cycle N+1 through N+2·WIDTH·DIV.
- At cycle N+1+2·WIDTH·DIV: `busy` = 0 and `done` = 1.
- `sclk` is low for cycles N+1..N+DIV, then alternates every DIV cycles. This gives exactly WIDTH rising edges per transfer.
- `sdo` is stable across each `sclk` high phase. It changes only coincident with falling toggles, so the receiver samples on the rising edge.
- Back-to-back transfers: the `done` cycle is an IDLE cycle. If `en && start` is sampled there, the next transfer's `busy` rises in the following cycle, giving a one-cycle gap.
- `done` and `abort` are never high in the same cycle, and neither is ever high while `busy` is high.

## Test plan
- Loopback, WIDTH=4, DIV=1, `sdi` = `sdo`, `din` = 4'b1010, `en` pulsed with `start` held high:
  - `busy` is high for 8 cycles and `sclk` shows 4 pulses.
  - `sdo` bits are 1, 0, 1, 0; `done` is a one-cycle pulse; `dout` = 4'b1010.
- DIV=2, `sdi` tied 1, `din` = 4'h3:
  - `busy` is high for 16 cycles and each `sclk` phase lasts 2 cycles.
  - `dout` = 4'hF; `sdo` bits are 0, 0, 1, 1.
- Abort: `start` dropped on the 3rd SHIFT cycle (DIV=1):
  - Next cycle: `abort` = 1, `busy` = 0, `sclk` = 0.
  - `dout` keeps its previous value; no `done` pulse.
- Request qualification: `start` = 1 with `en` = 0 gives no transfer. `en` = 1 with `start` = 0 gives no transfer. `en` pulsed during SHIFT has no effect.
- Back-to-back: `en && start` held through the `done` cycle. The second transfer starts with exactly one idle cycle between the two `busy` windows, and both `dout` values are correct.
- Reset asserted mid-SHIFT:
  - Next cycle: all outputs 0 and `dout` = 0.
  - A new request after reset completes normally.

Source files
------------

// File: rtl/serial_xfer_ctrl_if.sv
// rtl/serial_xfer_ctrl_if.sv - request, data and serial-line bundle for serial_xfer_ctrl
interface serial_xfer_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             start;
    logic [WIDTH-1:0] din;
    logic             sdi;
    logic             sclk;
    logic             sdo;
    logic             busy;
    logic             done;
    logic             abort;
    logic [WIDTH-1:0] dout;

    modport master (
        output en, start, din, sdi,
        input  sclk, sdo, busy, done, abort, dout
    );

    modport slave (
        input  en, start, din, sdi,
        output sclk, sdo, busy, done, abort, dout
    );
endinterface

// File: rtl/serial_xfer_ctrl.sv
// rtl/serial_xfer_ctrl.sv - full-duplex serial transfer sequencer (sclk/sdo/sdi, MSB first)
module serial_xfer_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic              clk,
    input  logic              rst,
    serial_xfer_ctrl_if.slave bus
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW = $clog2(2 * WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [DW-1:0]    div_cnt;
    logic [TW-1:0]    tog_cnt;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] dout_r;
    logic             sclk_r;
    logic             sdo_r;
    logic             busy_r;
    logic             done_r;
    logic             abort_r;

    // Shifted views of the TX/RX registers; written as shifts so WIDTH=1 needs no special case
    always_comb begin
        tx_next    = tx_sr << 1;
        rx_next    = rx_sr << 1;
        rx_next[0] = bus.sdi;
    end

    // Transfer sequencer: accept, sclk divider/toggle counting, shifting, completion and abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            tog_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            dout_r  <= '0;
            sclk_r  <= 1'b0;
            sdo_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            abort_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && bus.start) begin
                        state   <= SHIFT;
                        tx_sr   <= bus.din;
                        rx_sr   <= '0;
                        sdo_r   <= bus.din[WIDTH-1];
                        sclk_r  <= 1'b0;
                        div_cnt <= '0;
                        tog_cnt <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!bus.start) begin
                        // Abort wins over everything else, including a coincident completion
                        state   <= IDLE;
                        sclk_r  <= 1'b0;
                        sdo_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        abort_r <= 1'b1;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        tog_cnt <= tog_cnt + TW'(1);
                        if (!sclk_r) begin
                            sclk_r <= 1'b1;
                            rx_sr  <= rx_next;
                        end else if (tog_cnt == TOG_LAST) begin
                            state  <= IDLE;
                            dout_r <= rx_sr;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            sclk_r <= 1'b0;
                            sdo_r  <= 1'b0;
                        end else begin
                            sclk_r <= 1'b0;
                            tx_sr  <= tx_next;
                            sdo_r  <= tx_next[WIDTH-1];
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sclk  = sclk_r;
    assign bus.sdo   = sdo_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.abort = abort_r;
    assign bus.dout  = dout_r;
endmodule
